// File: rtl/prng_stream_reader.sv
// prng_stream_reader: buffers 256-bit PRNG words in a small FIFO and serves them as OUT_W-bit slices.
// Define PRNG_STREAM_HEALTH_EN to reject repeated or all-zero words and raise a sticky health flag.
module prng_stream_reader #(
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [255:0]                 in_word,
    input  logic                         in_valid,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  drop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         health_fail
);
    localparam int N  = 256 / OUT_W;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        EMPTY,
        LOADED
    } state_t;

    state_t            state_q;
    logic [255:0]      fifoMem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [255:0]      sr_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idxNext;
    logic [OUT_W-1:0]  outData_q;
    logic              outValid_q;
    logic [15:0]       dropCnt_q;
    logic              healthFail;
    logic [255:0]      headWord;
    logic              fifoNonEmpty;
    logic              handshake;
    logic              lastSlice;
    logic              pop;
    logic              push;
    logic              drop;
    logic              wordOk;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef PRNG_STREAM_HEALTH_EN
    logic [255:0] prev_q;
    logic         healthFail_q;
    logic         healthBad;

    assign healthBad  = in_valid && ((in_word == prev_q) || (in_word == '0));
    assign wordOk     = in_valid && !healthBad;
    assign healthFail = healthFail_q;

    // prev tracks the last word that passed, even if that word is later dropped for full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            healthFail_q <= 1'b0;
        end else begin
            if (wordOk) begin
                prev_q <= in_word;
            end
            if (healthBad) begin
                healthFail_q <= 1'b1;
            end
        end
    end
`else
    assign wordOk     = in_valid;
    assign healthFail = 1'b0;
`endif

    assign fifoNonEmpty = (count_q != '0);
    assign handshake    = outValid_q && out_ready;
    assign lastSlice    = (idx_q == IW'(N - 1));
    assign idxNext      = idx_q + IW'(1);
    assign headWord     = fifoMem_q[rdPtr_q];

    // A pop in the same cycle frees a slot, so a full FIFO can still take the incoming word
    assign pop  = fifoNonEmpty && ((state_q == EMPTY) || (handshake && lastSlice));
    assign push = wordOk && ((count_q < CW'(DEPTH)) || pop);
    assign drop = wordOk && !push;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (pop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= in_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            dropCnt_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (drop && (dropCnt_q != 16'hFFFF)) begin
                dropCnt_q <= dropCnt_q + 16'd1;
            end
        end
    end

    // Serializer: the output slice is registered alongside sr/idx so out_data never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            sr_q       <= '0;
            idx_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (pop) begin
                        sr_q       <= headWord;
                        idx_q      <= '0;
                        outData_q  <= headWord[OUT_W-1:0];
                        outValid_q <= 1'b1;
                        state_q    <= LOADED;
                    end
                end
                LOADED: begin
                    if (handshake) begin
                        if (!lastSlice) begin
                            idx_q     <= idxNext;
                            outData_q <= sr_q[OUT_W*idxNext +: OUT_W];
                        end else if (pop) begin
                            sr_q      <= headWord;
                            idx_q     <= '0;
                            outData_q <= headWord[OUT_W-1:0];
                        end else begin
                            outValid_q <= 1'b0;
                            state_q    <= EMPTY;
                        end
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_data    = outData_q;
    assign out_valid   = outValid_q;
    assign drop_cnt    = dropCnt_q;
    assign level       = count_q;
    assign health_fail = healthFail;

endmodule

// File: tb/tb_prng_stream_reader.sv
// Self-checking bench for prng_stream_reader: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_prng_stream_reader;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;
    localparam int N     = 256 / OUT_W;
`ifdef PRNG_STREAM_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [255:0]       in_word = '0;
    logic               in_valid = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [15:0]        drop_cnt;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic               health_fail;

    int checksTotal  = 0;
    int checksPassed = 0;

    prng_stream_reader #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt), .level(level), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of buffered words plus the word being served and its slice number
    logic [255:0] fifoQ[$];
    bit           mValid = 1'b0;
    logic [255:0] mWord  = '0;
    int           mSlice = 0;
    int           mDrop  = 0;
    bit           mFail  = 1'b0;
    logic [255:0] mPrev  = '0;

    function automatic logic [OUT_W-1:0] sliceOf(input logic [255:0] w, input int s);
        logic [255:0] t;
        t = w >> (s * OUT_W);
        return t[OUT_W-1:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                fifoQ.delete();
                mValid = 1'b0; mWord = '0; mSlice = 0; mDrop = 0; mFail = 1'b0; mPrev = '0;
            end else begin
                bit hs, doPop, ok, wasFull;
                logic [255:0] w;
                hs      = mValid && out_ready;
                doPop   = (fifoQ.size() > 0) && (!mValid || (hs && mSlice == N - 1));
                wasFull = (fifoQ.size() == DEPTH);
                ok      = in_valid;
                w       = in_word;
                if (HEALTH && in_valid) begin
                    if (w == mPrev || w == '0) begin
                        ok = 1'b0;
                        mFail = 1'b1;
                    end else begin
                        mPrev = w;
                    end
                end
                if (doPop) begin
                    mWord  = fifoQ.pop_front();
                    mSlice = 0;
                    mValid = 1'b1;
                end else if (hs) begin
                    if (mSlice < N - 1) mSlice++;
                    else mValid = 1'b0;
                end
                if (ok) begin
                    if (!wasFull || doPop) fifoQ.push_back(w);
                    else if (mDrop < 16'hFFFF) mDrop++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [255:0] w, input logic r);
        in_valid  = v;
        in_word   = w;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic doReset();
        in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [255:0] mkWord(input int b);
        logic [255:0] w;
        w = '0;
        for (int j = 0; j < N; j++) w[j*OUT_W +: OUT_W] = OUT_W'(b * 256 + j);
        return w;
    endfunction

    function automatic logic [255:0] randWord();
        logic [255:0] w;
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("out_valid", out_valid, mValid);
            if (mValid) checkOutput("out_data", out_data, sliceOf(mWord, mSlice));
            checkOutput("level", level, fifoQ.size());
            checkOutput("drop_cnt", drop_cnt, mDrop);
            checkOutput("health_fail", health_fail, mFail);
        end
    end

    initial begin
        logic [255:0] specWord, hw, lastW;
        specWord = 256'h0000000800000007_0000000600000005_0000000400000003_0000000200000001;
        @(negedge clk);

        $display("[TB] reset values");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_data", out_data, 0);
            checkOutput("rst_level", level, 0);
            checkOutput("rst_drop_cnt", drop_cnt, 0);
            checkOutput("rst_health", health_fail, 0);
        end

        $display("[TB] single word");
        applyStimulus(1'b1, specWord, 1'b1);
        checkOutput("single_lat_valid", out_valid, 0);
        checkOutput("single_lat_level", level, 1);
        for (int j = 0; j < N; j++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("single_valid", out_valid, 1);
            checkOutput("single_data", out_data, j + 1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_end_valid", out_valid, 0);

        $display("[TB] back-pressure and full");
        doReset();
        for (int b = 1; b <= 4; b++) applyStimulus(1'b1, mkWord(b), 1'b0);
        checkOutput("bp_level", level, 2);
        checkOutput("bp_drop", drop_cnt, 1);
        checkOutput("bp_head", out_data, 32'h100);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            checkOutput("bp_stream_valid", out_valid, 1);
            checkOutput("bp_stream_data", out_data, (i / N + 1) * 256 + i % N);
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("bp_end_valid", out_valid, 0);

        $display("[TB] full plus pop");
        doReset();
        applyStimulus(1'b1, mkWord(10), 1'b0);
        applyStimulus(1'b1, mkWord(11), 1'b0);
        applyStimulus(1'b1, mkWord(12), 1'b0);
        for (int i = 0; i < N - 1; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fp_last_slice", out_data, 10 * 256 + N - 1);
        applyStimulus(1'b1, mkWord(13), 1'b1);
        checkOutput("fp_level", level, 2);
        checkOutput("fp_drop", drop_cnt, 0);
        checkOutput("fp_next_word", out_data, 11 * 256);
        for (int i = 0; i < 3 * N + 2; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fp_drained", out_valid, 0);

        $display("[TB] health check");
        doReset();
        hw = mkWord(20);
        applyStimulus(1'b1, hw, 1'b0);
        applyStimulus(1'b1, hw, 1'b0);
        checkOutput("hc_fail_after_repeat", health_fail, HEALTH);
        applyStimulus(1'b1, '0, 1'b0);
        checkOutput("hc_fail_sticky", health_fail, HEALTH);
        checkOutput("hc_drop", drop_cnt, 0);
        checkOutput("hc_level", level, HEALTH ? 0 : 2);
        checkOutput("hc_first_slice", out_data, 20 * 256);
        for (int i = 0; i < 3 * N + 2; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("hc_drained", out_valid, 0);

        $display("[TB] reset mid-word");
        doReset();
        applyStimulus(1'b1, specWord, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("mid_slice3", out_data, 4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_data", out_data, 0);
        checkOutput("mid_rst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, mkWord(30), 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("mid_restart_slice0", out_data, 30 * 256);

        $display("[TB] randomized traffic");
        doReset();
        lastW = randWord();
        for (int c = 0; c < 3000; c++) begin
            logic [255:0] w;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) w = '0;
            else if (sel <= 2) w = lastW;
            else w = randWord();
            lastW = w;
            if (c == 1500) doReset();
            applyStimulus(($urandom_range(0, 3) != 0), w, (c < 1000) ? 1'b1 : ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule

// File: doc/prng_stream_reader.md
# prng_stream_reader

Consumer end of the 256-bit PRNG stream: accepts the per-cycle `result` words of `xorshift256` (or any 256-bit random source), buffers them, and serves them as narrow `OUT_W`-bit slices over a valid/ready handshake to downstream logic such as elliptic-curve scalar generation. The source has no back-pressure, so words arriving while the buffer is full are discarded and counted. An optional health check rejects repeated or all-zero words.

## Interface

- `OUT_W`, default 32: output slice width. Must divide 256. `N = 256/OUT_W` slices per word.
- `DEPTH`, default 2: buffer depth in 256-bit words, at least 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_word` input 256: random word from the generator.
- `in_valid` input 1: `in_word` is valid this cycle. May be tied high.
- `out_data` output `OUT_W`: current slice.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts `out_data` this cycle.
- `drop_cnt` output 16: number of words discarded because the buffer was full. Saturates at 16'hFFFF.
- `level` output `$clog2(DEPTH+1)`: number of words held in the buffer, excluding the word being served.
- `health_fail` output 1: sticky health-check failure flag.

## Operation

**Buffer**
- Circular FIFO of `DEPTH` 256-bit entries, with write pointer, read pointer and count. Pointers wrap from `DEPTH-1` to 0.
- A word is accepted when `in_valid=1` and either `count<DEPTH` or a pop (load) occurs in the same cycle.
- When `in_valid=1` and the buffer is full with no pop, the word is discarded and `drop_cnt` increments, saturating.

**Serializer FSM**
- Serving register `sr[255:0]` plus slice index `idx` (0..N-1).
- `out_data = sr[OUT_W*idx +: OUT_W]`, so the least significant slice goes out first.
- State EMPTY: `out_valid=0`. If the FIFO is non-empty, pop into `sr`, set `idx=0`, go to LOADED.
- State LOADED: `out_valid=1`. On a handshake (`out_valid & out_ready`):
  - If `idx<N-1`: `idx` increments.
  - If `idx=N-1` and the FIFO is non-empty: pop the next word in the same cycle, set `idx=0`, stay in LOADED. Slices are back-to-back with no bubble.
  - If `idx=N-1` and the FIFO is empty: go to EMPTY.
- With no handshake, `out_data` and `out_valid` hold stable.

**Reset**
- Asserting `rst_n` low forces the following immediately, including mid-word:
  - state EMPTY, `out_valid=0`, `out_data=0`
  - `sr=0`, `idx=0`, pointers 0, count 0, `level=0`
  - `drop_cnt=0`, `health_fail=0`
- Any partially served word is lost.

## Timing

- Word sampled at edge k (FIFO was empty, FSM in EMPTY): `level=1` after edge k, popped at edge k+1, `out_valid=1` after edge k+1. Latency is 2 cycles.
- With `out_ready` held high, one slice is delivered per cycle. A full word takes N cycles.
- Sustained throughput is `OUT_W` bits per cycle. With an always-valid source, `N-1` of every `N` words are dropped in steady state.
- The full-and-pop case in the same cycle accepts the new word; `level` is unchanged.
- `drop_cnt` and `health_fail` update on the edge after the offending input.

## Configuration

- Macro `PRNG_STREAM_HEALTH_EN`.
- **Defined:**
  - Register `prev` (256 bits, reset 0) holds the last word that passed the check.
  - An incoming valid word equal to `prev`, or equal to all-zero, fails the check. A failing word is never written to the FIFO and does not count in `drop_cnt`.
  - On failure, `health_fail` is set and stays set until reset.
  - `prev` updates on every passing word, whether or not it is then dropped for full.
- **Undefined:**
  - No compare logic and no `prev` register.
  - `health_fail` is tied to 0 and every valid word is subject only to the full rule.

## Test plan

- **Reset values:** reset, then release with `in_valid=0` -> all outputs are 0 and stay 0 for 10 cycles.
- **Single word, OUT_W=32:** one `in_word=256'h0000000800000007_0000000600000005_0000000400000003_0000000200000001`, `out_ready=1` -> `out_valid` rises 2 cycles after sampling; `out_data` reads 1,2,…,8 on consecutive cycles; `out_valid` then falls.
- **Back-pressure and full:** `DEPTH=2`, `out_ready=0`, four distinct words on consecutive cycles -> the first word sits in `sr`, the next two are buffered (`level=2`), the fourth is dropped (`drop_cnt=1`). Release `out_ready` -> 24 slices with no bubble, in order, then `out_valid=0`.
- **Full plus pop in the same cycle:** buffer full, last slice handshaken while a new word arrives -> word accepted, `level` stays 2, `drop_cnt` unchanged.
- **Health check (macro defined):** the same word twice, then `256'h0` -> one copy is served; `health_fail=1` after the second word; `drop_cnt=0`. With the macro undefined -> all three words are buffered or served and `health_fail=0`.
- **Reset mid-word:** pull `rst_n` low after 3 of 8 slices -> `out_valid` drops at once; after release, the next word starts at slice 0.
